// File: rtl/dh_responder.sv
// Diffie-Hellman responder: byte-serial A in, B = g^b mod p out, S = A^b mod p.
// Ports: clk/rst, prime/gen/secret, rx byte stream, tx byte stream, shared/done/busy/err.
module dh_responder #(
  parameter int W = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] prime,
  input  logic [W-1:0] gen,
  input  logic [W-1:0] secret,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [W-1:0] shared,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int NB = (W + 7) / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_EXPB,
    S_EXPS,
    S_SEND
  } state_t;

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   r_q;
  logic [W-1:0]   acc_q;
  logic [CW-1:0]  bit_q;
  logic [CW-1:0]  step_q;
  logic           phase_q;
  logic [W-1:0]   shared_q;
  logic           err_q;
  logic           done_q;

  logic           rx_fire;
  logic           tx_fire;
  logic [W-1:0]   base;
  logic [W-1:0]   y_v;
  logic           ybit;
  logic [W:0]     t1;
  logic [W:0]     t2;
  logic [W-1:0]   mm_d;
  logic [W-1:0]   r_fin_d;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_RECV);
  assign busy     = !rx_ready;
  assign tx_valid = (state_q == S_SEND);
  assign tx_data  = tx_valid ? 8'(b_q >> {idx_q, 3'b000}) : 8'h00;
  assign shared   = shared_q;
  assign done     = done_q;
  assign err      = err_q;

  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  // One step of the interleaved modular multiply: x is always R,
  // y is R for the square phase and the base for the multiply phase.
  always_comb begin
    base = (state_q == S_EXPB) ? gen : a_q;
    y_v  = phase_q ? base : r_q;
    ybit = y_v[step_q];
    t1   = {acc_q, 1'b0};
    if (t1 >= {1'b0, prime}) t1 = t1 - {1'b0, prime};
    t2 = t1;
    if (ybit) begin
      t2 = t1 + {1'b0, r_q};
      if (t2 >= {1'b0, prime}) t2 = t2 - {1'b0, prime};
    end
    mm_d    = t2[W-1:0];
    r_fin_d = secret[0] ? mm_d : r_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
      step_q   <= '0;
      phase_q  <= 1'b0;
      shared_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            err_q <= 1'b0;
            a_q   <= W'(rx_data);
            idx_q <= IW'(1);
            state_q <= (NB == 1) ? S_CHECK : S_RECV;
          end
        end
        S_RECV: begin
          if (rx_fire) begin
            a_q <= a_q | (W'(rx_data) << {idx_q, 3'b000});
            if (idx_q == IW'(NB - 1)) state_q <= S_CHECK;
            else idx_q <= idx_q + IW'(1);
          end
        end
        S_CHECK: begin
          if (a_q == '0 || a_q >= prime) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            shared_q <= '0;
            r_q      <= W'(1);
            acc_q    <= '0;
            bit_q    <= CW'(W - 1);
            step_q   <= CW'(W - 1);
            phase_q  <= 1'b0;
            state_q  <= S_EXPB;
          end
        end
        S_EXPB, S_EXPS: begin
          acc_q  <= mm_d;
          step_q <= step_q - CW'(1);
          if (step_q == '0) begin
            acc_q  <= '0;
            step_q <= CW'(W - 1);
            if (!phase_q) begin
              r_q     <= mm_d;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (secret[bit_q]) r_q <= mm_d;
              if (bit_q == '0) begin
                bit_q <= CW'(W - 1);
                if (state_q == S_EXPB) begin
                  b_q     <= r_fin_d;
                  r_q     <= W'(1);
                  state_q <= S_EXPS;
                end else begin
                  r_q     <= r_fin_d;
                  idx_q   <= '0;
                  state_q <= S_SEND;
                end
              end else begin
                bit_q <= bit_q - CW'(1);
              end
            end
          end
        end
        S_SEND: begin
          if (tx_fire) begin
            if (idx_q == IW'(NB - 1)) begin
              shared_q <= r_q;
              done_q   <= 1'b1;
              idx_q    <= '0;
              state_q  <= S_IDLE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_responder.sv
// Directed bench for dh_responder: W=8 instance for protocol and edge cases,
// W=100 instance for the full-width exchange with tx backpressure.
module tb_dh_responder;

  logic clk;
  logic rst;

  logic [7:0]  s_prime, s_gen, s_secret;
  logic [7:0]  s_rx_data, s_tx_data;
  logic        s_rx_valid, s_rx_ready, s_tx_valid, s_tx_ready;
  logic [7:0]  s_shared;
  logic        s_done, s_busy, s_err;

  logic [99:0] l_prime, l_gen, l_secret;
  logic [7:0]  l_rx_data, l_tx_data;
  logic        l_rx_valid, l_rx_ready, l_tx_valid, l_tx_ready;
  logic [99:0] l_shared;
  logic        l_done, l_busy, l_err;

  int n_checks;
  int n_err;

  dh_responder #(.W(8)) u_s (
    .clk(clk), .rst(rst),
    .prime(s_prime), .gen(s_gen), .secret(s_secret),
    .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready),
    .shared(s_shared), .done(s_done), .busy(s_busy), .err(s_err)
  );

  dh_responder #(.W(100)) u_l (
    .clk(clk), .rst(rst),
    .prime(l_prime), .gen(l_gen), .secret(l_secret),
    .rx_data(l_rx_data), .rx_valid(l_rx_valid), .rx_ready(l_rx_ready),
    .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(l_tx_ready),
    .shared(l_shared), .done(l_done), .busy(l_busy), .err(l_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xchg8(input logic [7:0] a, input logic [7:0] exp_b,
                       input logic [7:0] exp_s);
    int cyc;
    chk("s_rdy_pre", s_rx_ready, 1'b1);
    s_rx_data  = a;
    s_rx_valid = 1'b1;
    tick();
    s_rx_valid = 1'b0;
    chk("s_err_clr", s_err, 1'b0);
    chk("s_busy_chk", s_busy, 1'b1);
    chk("s_rdy_busy", s_rx_ready, 1'b0);
    cyc = 0;
    while (!s_tx_valid && cyc < 600) begin
      tick();
      cyc++;
    end
    chk("s_latency", cyc, 257);
    chk("s_tx_b", s_tx_data, exp_b);
    tick();
    chk("s_done", s_done, 1'b1);
    chk("s_shared", s_shared, exp_s);
    chk("s_txv_off", s_tx_valid, 1'b0);
    chk("s_rdy_done", s_rx_ready, 1'b1);
    chk("s_err_ok", s_err, 1'b0);
    tick();
    chk("s_done_pulse", s_done, 1'b0);
  endtask

  task automatic reject8(input logic [7:0] a, input logic [7:0] keep_s);
    s_rx_data  = a;
    s_rx_valid = 1'b1;
    tick();
    s_rx_valid = 1'b0;
    chk("s_rej_err0", s_err, 1'b0);
    chk("s_rej_busy", s_busy, 1'b1);
    tick();
    chk("s_rej_err1", s_err, 1'b1);
    chk("s_rej_rdy", s_rx_ready, 1'b1);
    chk("s_rej_busy0", s_busy, 1'b0);
    chk("s_rej_txv", s_tx_valid, 1'b0);
    chk("s_rej_shared", s_shared, keep_s);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [7:0] eb;
    n_checks = 0;
    n_err    = 0;
    rst = 1'b0;
    s_prime = 8'd23; s_gen = 8'd5; s_secret = 8'd6;
    s_rx_data = 8'h00; s_rx_valid = 1'b0; s_tx_ready = 1'b1;
    l_prime = 100'd23; l_gen = 100'd5; l_secret = 100'd6;
    l_rx_data = 8'h00; l_rx_valid = 1'b0; l_tx_ready = 1'b0;

    repeat (3) tick();
    chk("rst_rdy", s_rx_ready, 1'b1);
    chk("rst_txv", s_tx_valid, 1'b0);
    chk("rst_txd", s_tx_data, 8'h00);
    chk("rst_done", s_done, 1'b0);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_err", s_err, 1'b0);
    chk("rst_shared", s_shared, 8'h00);
    chk("rst_l_txv", l_tx_valid, 1'b0);
    chk("rst_l_shared", l_shared, 100'd0);
    rst = 1'b1;
    tick();

    xchg8(8'h0A, 8'h08, 8'd6);

    reject8(8'h00, 8'd6);
    reject8(8'd23, 8'd6);
    xchg8(8'h0A, 8'h08, 8'd6);

    s_secret = 8'd0;
    xchg8(8'h0A, 8'h01, 8'd1);
    s_secret = 8'd1;
    xchg8(8'h0A, 8'h05, 8'd10);
    s_secret = 8'd6;

    s_rx_data  = 8'h0A;
    s_rx_valid = 1'b1;
    tick();
    s_rx_valid = 1'b0;
    repeat (51) tick();
    chk("mid_busy", s_busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_busy0", s_busy, 1'b0);
    chk("mid_txv", s_tx_valid, 1'b0);
    chk("mid_rdy", s_rx_ready, 1'b1);
    chk("mid_shared", s_shared, 8'h00);
    seen = 0;
    repeat (300) begin
      tick();
      if (s_tx_valid) seen++;
    end
    chk("mid_no_tx", seen, 0);
    xchg8(8'h0A, 8'h08, 8'd6);

    for (int k = 0; k < 13; k++) begin
      l_rx_data  = (k == 0) ? 8'h0A : 8'h00;
      l_rx_valid = 1'b1;
      tick();
    end
    l_rx_valid = 1'b0;
    chk("l_busy", l_busy, 1'b1);
    cyc = 0;
    while (!l_tx_valid && cyc < 41000) begin
      tick();
      cyc++;
    end
    chk("l_latency", cyc, 40001);
    for (int k = 0; k < 13; k++) begin
      eb = (k == 0) ? 8'h08 : 8'h00;
      if (k == 0 || k == 7) begin
        l_tx_ready = 1'b0;
        repeat (5) begin
          chk("l_hold_v", l_tx_valid, 1'b1);
          chk("l_hold_d", l_tx_data, eb);
          tick();
        end
      end
      l_tx_ready = 1'b1;
      chk("l_txv", l_tx_valid, 1'b1);
      chk("l_txd", l_tx_data, eb);
      chk("l_done_early", l_done, 1'b0);
      tick();
    end
    l_tx_ready = 1'b0;
    chk("l_done", l_done, 1'b1);
    chk("l_shared", l_shared, 100'd6);
    chk("l_txv_off", l_tx_valid, 1'b0);
    chk("l_err", l_err, 1'b0);
    chk("l_rdy", l_rx_ready, 1'b1);
    tick();
    chk("l_done_pulse", l_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
